// File: rtl/window3x3_gen_pkg.sv
// Shared constants and types for the 3x3 window generator.
//
// IMG_DATA_WIDTH        default pixel width in bits
// WIN_TAPS              number of pixels in one window (3x3)
// IMG_DATA_MATRIX_WIDTH packed window width for the default pixel width
// WIN_ST_FILL/RUN       state encodings of the fill/run FSM
package window3x3_gen_pkg;

  localparam int unsigned IMG_DATA_WIDTH        = 8;
  localparam int unsigned WIN_TAPS              = 9;
  localparam int unsigned IMG_DATA_MATRIX_WIDTH = WIN_TAPS * IMG_DATA_WIDTH;

  localparam logic WIN_ST_FILL = 1'b0;
  localparam logic WIN_ST_RUN  = 1'b1;

  typedef enum logic {
    StFill = WIN_ST_FILL,
    StRun  = WIN_ST_RUN
  } win_state_e;

  // Saturating 16-bit increment for the debug window counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/window3x3_gen_line_delay.sv
// line_delay: one image row of delay, DATA_W x DEPTH circular RAM.
//
// A single index addresses both the read and the write port. The read is
// combinational and returns the value written DEPTH accepted pixels ago at
// the same column; the write of the current pixel lands on the next edge.
//
// Ports:
//   clk_i    clock, rising edge
//   we_i     write enable (pixel accepted)
//   idx_i    column index, shared by read and write
//   wdata_i  value stored at idx_i
//   rdata_o  value currently stored at idx_i
module line_delay #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // No reset: stale contents are never used because the window is only
  // emitted once two full rows have been written.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/window3x3_gen.sv
// window3x3_gen: raster pixel stream to packed 3x3 window ("valid" windows only).
//
// Buffers the two previous rows in two line_delay instances and keeps a 3x3
// shift window. One window is emitted, one clock after the completing pixel,
// for every accepted pixel at row>=2 and col>=2.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   ena        global enable; 0 stalls everything
//   pix_valid  pix_in valid (accepted only with ena)
//   pix_sof    pix_in is pixel (0,0) of a new frame
//   pix_in     input pixel
//   win_out    {p00,p01,p02,p10,p11,p12,p20,p21,p22}, p00 in the MSBs
//   win_valid  single-cycle pulse: win_out holds a new window
//   frame_done pulse: last pixel of the frame accepted on the previous cycle
//   win_cnt    (only with WIN_CNT_EN) windows emitted in the current frame
//
// Build option: define WIN_CNT_EN to add the saturating win_cnt debug output.
module window3x3_gen
  import window3x3_gen_pkg::*;
#(
  parameter int unsigned DATA_W = IMG_DATA_WIDTH,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       pix_valid,
  input  logic                       pix_sof,
  input  logic [DATA_W-1:0]          pix_in,
  output logic [WIN_TAPS*DATA_W-1:0] win_out,
  output logic                       win_valid,
  output logic                       frame_done
`ifdef WIN_CNT_EN
  ,
  output logic [15:0]                win_cnt
`endif
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned WinW = WIN_TAPS * DATA_W;

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  logic              accept;
  logic              emit;
  logic [ColW-1:0]   idx;
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;
  logic [DATA_W-1:0] col_new [3];
  logic [DATA_W-1:0] shift_nxt [3][3];
  logic [WinW-1:0]   win_flat;

  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  win_state_e        state_q, state_d;
  logic [WinW-1:0]   win_out_q, win_out_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] shift_q [3][3];
  logic [DATA_W-1:0] shift_d [3][3];

  // ---------------------------------------------------------------------------
  // Row buffers: lb0 holds the previous row, lb1 the row before that.
  // ---------------------------------------------------------------------------
  assign accept = ena & pix_valid;
  // A start-of-frame pixel is column 0 regardless of where the counter was.
  assign idx    = pix_sof ? '0 : col_q;

  line_delay #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .IDX_W  (ColW)
  ) u_lb0 (
    .clk_i   (clk),
    .we_i    (accept),
    .idx_i   (idx),
    .wdata_i (pix_in),
    .rdata_o (lb0_rd)
  );

  line_delay #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .IDX_W  (ColW)
  ) u_lb1 (
    .clk_i   (clk),
    .we_i    (accept),
    .idx_i   (idx),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // ---------------------------------------------------------------------------
  // Window shift: every row moves left, the new column enters on the right.
  // ---------------------------------------------------------------------------
  always_comb begin
    col_new[0] = lb1_rd;
    col_new[1] = lb0_rd;
    col_new[2] = pix_in;
    for (int r = 0; r < 3; r++) begin
      shift_nxt[r][0] = shift_q[r][1];
      shift_nxt[r][1] = shift_q[r][2];
      shift_nxt[r][2] = col_new[r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_flat[(8 - (r * 3 + c)) * DATA_W +: DATA_W] = shift_nxt[r][c];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        shift_d[r][c] = accept ? shift_nxt[r][c] : shift_q[r][c];
      end
    end
  end

  // Window contents need no reset: nothing is emitted until they are refilled.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // ---------------------------------------------------------------------------
  // Position counters, FILL/RUN state and registered outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (accept) begin
      if (pix_sof) begin
        col_d = ColW'(1);
        row_d = '0;
      end else if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // RUN exactly while two complete rows sit in the line buffers.
      state_d = (row_d >= RowW'(2)) ? StRun : StFill;
    end
  end

  assign emit = accept & ~pix_sof & (state_q == StRun) & (col_q >= ColW'(2));

  always_comb begin
    win_valid_d  = emit;
    win_out_d    = emit ? win_flat : win_out_q;
    frame_done_d = accept & ~pix_sof & (col_q == ColLast) & (row_q == RowLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= StFill;
      win_out_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      state_q      <= state_d;
      win_out_q    <= win_out_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_out    = win_out_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

`ifdef WIN_CNT_EN
  // ---------------------------------------------------------------------------
  // Debug window counter. It moves together with win_valid so it already
  // includes the final window while frame_done is high.
  // ---------------------------------------------------------------------------
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [15:0] cnt_base;

  always_comb begin
    cnt_base  = ((accept & pix_sof) | frame_done_q) ? 16'd0 : win_cnt_q;
    win_cnt_d = emit ? sat_inc16(cnt_base) : cnt_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

  assign win_cnt = win_cnt_q;
`endif

endmodule
